// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared frame-buffer geometry and fill-engine state encoding
package vga_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 360;
  localparam int VRAM_DEPTH    = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int VRAM_A_WIDTH  = 18;
  localparam int VRAM_D_WIDTH  = 6;

  typedef enum logic [1:0] {
    IDLE,
    CLIP,
    FILL,
    DONE
  } fill_state_e;

endpackage

// File: rtl/vram_rect_fill_clip.sv
// rtl/vram_rect_fill_clip.sv - clips a rectangle to the screen, yielding exclusive end column/row
module vram_rect_fill_clip
  import vga_pkg::*;
#(
  parameter int SCREEN_WIDTH  = vga_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = vga_pkg::SCREEN_HEIGHT
) (
  input  logic [9:0]  x0,
  input  logic [8:0]  y0,
  input  logic [9:0]  w,
  input  logic [8:0]  h,
  output logic [10:0] xe,
  output logic [9:0]  ye,
  output logic        empty
);

  localparam logic [10:0] SW = 11'(SCREEN_WIDTH);
  localparam logic [9:0]  SH = 10'(SCREEN_HEIGHT);

  logic [10:0] sum_x;
  logic [9:0]  sum_y;

  // One extra bit on each sum so an origin near the edge plus a large size cannot wrap
  assign sum_x = {1'b0, x0} + {1'b0, w};
  assign sum_y = {1'b0, y0} + {1'b0, h};
  assign xe    = (sum_x > SW) ? SW : sum_x;
  assign ye    = (sum_y > SH) ? SH : sum_y;
  assign empty = (w == 10'd0) || (h == 9'd0) || ({1'b0, x0} >= SW) || ({1'b0, y0} >= SH);

endmodule

// File: rtl/vram_rect_fill.sv
// rtl/vram_rect_fill.sv - rectangle-fill write engine: clips a command and emits one VRAM write per pixel
module vram_rect_fill
  import vga_pkg::*;
#(
  parameter int SCREEN_WIDTH  = vga_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = vga_pkg::SCREEN_HEIGHT,
  parameter int ADDR_WIDTH    = VRAM_A_WIDTH,
  parameter int DATA_WIDTH    = VRAM_D_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [9:0]            i_x0,
  input  logic [8:0]            i_y0,
  input  logic [9:0]            i_w,
  input  logic [8:0]            i_h,
  input  logic [DATA_WIDTH-1:0] i_colour,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_write,
  input  logic                  i_wr_gnt,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(SCREEN_WIDTH);

  fill_state_e state, state_next;

  logic [9:0]            x0_q;
  logic [8:0]            y0_q;
  logic [9:0]            w_q;
  logic [8:0]            h_q;
  logic [DATA_WIDTH-1:0] colour_q;
  logic [10:0]           xe_q;
  logic [9:0]            ye_q;
  logic [9:0]            cx;
  logic [8:0]            cy;
  logic [ADDR_WIDTH-1:0] row_base;

  logic [10:0] xe_c;
  logic [9:0]  ye_c;
  logic        empty_c;
  logic        accept;
  logic        row_end;
  logic        last_row;

  vram_rect_fill_clip #(
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .SCREEN_HEIGHT(SCREEN_HEIGHT)
  ) u_clip (
    .x0   (x0_q),
    .y0   (y0_q),
    .w    (w_q),
    .h    (h_q),
    .xe   (xe_c),
    .ye   (ye_c),
    .empty(empty_c)
  );

  assign o_cmd_ready = (state == IDLE) && !i_rst;
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign row_end     = ({1'b0, cx} + 11'd1) >= xe_q;
  assign last_row    = ({1'b0, cy} + 10'd1) == ye_q;

  assign o_write = (state == FILL);
  assign o_addr  = o_write ? (row_base + ADDR_WIDTH'(cx)) : '0;
  assign o_data  = o_write ? colour_q : '0;
  assign o_busy  = (state != IDLE);
  assign o_done  = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = CLIP;
      CLIP: state_next = empty_c ? DONE : FILL;
      FILL: if (i_wr_gnt && row_end && last_row) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      colour_q <= '0;
      xe_q     <= '0;
      ye_q     <= '0;
      cx       <= '0;
      cy       <= '0;
      row_base <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          x0_q     <= i_x0;
          y0_q     <= i_y0;
          w_q      <= i_w;
          h_q      <= i_h;
          colour_q <= i_colour;
        end
        CLIP: begin
          xe_q     <= xe_c;
          ye_q     <= ye_c;
          row_base <= ADDR_WIDTH'(y0_q) * ROW_STRIDE;
          cx       <= x0_q;
          cy       <= y0_q;
        end
        // Row advance adds the stride so the pixel loop never needs a multiplier
        FILL: if (i_wr_gnt) begin
          if (!row_end) begin
            cx <= cx + 10'd1;
          end else begin
            cx       <= x0_q;
            cy       <= cy + 9'd1;
            row_base <= row_base + ROW_STRIDE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/vram_rect_fill.md
Name: vram_rect_fill

Overview:
Write-side engine for the 640x360 6-bit-per-pixel VRAM frame buffer. The display path reads this buffer. This block accepts rectangle-fill commands (origin, size, palette index) over a valid/ready handshake, clips them to the screen, and emits one VRAM write per pixel in raster order. It sits between a command source (CPU/sequencer) and the sram write port. Writes are gated by a grant from the port arbiter so display reads keep priority.

Parameters:
SCREEN_WIDTH, 640, pixels per row; also the row address stride
SCREEN_HEIGHT, 360, rows per frame
ADDR_WIDTH, 18, VRAM address width (2^18 > 640*360)
DATA_WIDTH, 6, palette-index bits per pixel

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  block can accept a command
i_x0  in  10  rectangle left column
i_y0  in  9  rectangle top row
i_w  in  10  width in pixels
i_h  in  9  height in rows
i_colour  in  DATA_WIDTH  palette index to write
o_addr  out  ADDR_WIDTH  VRAM write address
o_data  out  DATA_WIDTH  VRAM write data
o_write  out  1  write request
i_wr_gnt  in  1  arbiter grant; a write completes on a cycle with o_write && i_wr_gnt
o_busy  out  1  command in progress
o_done  out  1  one-cycle pulse when a command finishes

Behaviour:
- Reset: i_rst is sampled on the i_clk edge; synchronous, active-high.
  - State goes to IDLE.
  - o_cmd_ready=0 during the reset cycle, then 1 in IDLE.
  - o_write=0, o_busy=0, o_done=0, o_addr=0, o_data=0.
- IDLE:
  - o_cmd_ready=1.
  - On i_cmd_valid && o_cmd_ready, register x0, y0, w, h and colour, then go to CLIP.
  - o_cmd_ready=0 in every state other than IDLE.
- CLIP (1 cycle):
  - xe = min(x0+w, SCREEN_WIDTH); ye = min(y0+h, SCREEN_HEIGHT).
  - Use 11-bit and 10-bit sums so nothing wraps.
  - If w==0, h==0, x0>=SCREEN_WIDTH or y0>=SCREEN_HEIGHT, go to DONE with no writes.
  - Otherwise initialise:
    - row_base = y0*SCREEN_WIDTH (single constant multiply, registered here).
    - cx = x0, cy = y0.
    - Go to FILL.
- FILL:
  - o_write=1, o_addr = row_base + cx, o_data = colour.
  - Address and data are held stable while i_wr_gnt=0.
  - On a granted cycle:
    - If cx+1 < xe: cx++.
    - Else: cx = x0, cy++, row_base += SCREEN_WIDTH (no multiplier in the loop).
    - If cy+1 == ye at end of row: go to DONE.
  - o_busy=1 from CLIP through DONE inclusive.
- DONE (1 cycle):
  - o_done=1, o_write=0.
  - Next state is IDLE, with o_cmd_ready=1 on the following cycle.
- Latency:
  - Command accepted at edge N.
  - First o_write asserted in cycle N+2.
  - With continuous grant, the last write is in cycle N+1+W*H, where W and H are the clipped sizes.
  - o_done follows in the next cycle.
- Write count: exactly clipped W*H, each address written once, in raster order. No address ever reaches SCREEN_WIDTH*SCREEN_HEIGHT or beyond.
- Back-to-back commands: a new command is accepted only in IDLE, so there is a minimum 1 idle cycle between o_done and the next accept.
- Reset mid-FILL:
  - o_write drops at the reset edge; the remaining pixels are abandoned.
  - o_done is not pulsed.
- i_cmd_valid while busy: ignored; the source must hold it until o_cmd_ready.

Decomposition:
- Shared vga_pkg holds:
  - SCREEN_WIDTH, SCREEN_HEIGHT, VRAM_DEPTH, VRAM_A_WIDTH=18, VRAM_D_WIDTH=6.
  - The fill state enum {IDLE, CLIP, FILL, DONE}.
- The display top and this block both import vga_pkg.
- One natural sub-module: vram_wr_arb, a 2-requester port mux with display read fixed-priority. It drives i_wr_gnt and shares the sram port. It is specified separately; this block is tested with a stub grant.

Test Plan:
- Basic fill: cmd x0=10, y0=2, w=3, h=2, colour=0x2A, grant always 1 -> writes at 1290, 1291, 1292, 1930, 1931, 1932 with data 0x2A in cycles N+2..N+7; o_done at N+8; o_cmd_ready at N+9.
- Right/bottom clip: x0=638, y0=359, w=5, h=4 -> exactly 2 writes, at addresses 230398 and 230399, then o_done.
- Degenerate: w=0 (also x0=640) -> no o_write; o_done in cycle N+2.
- Grant stall: same cmd as basic; i_wr_gnt low for 3 cycles after the first write is asserted -> o_addr=1290 and o_data held across the stall; total of 6 writes, none duplicated.
- Reset mid-fill: full-screen cmd (0, 0, 640, 360); assert i_rst after 100 granted writes -> o_write=0 and o_busy=0 at the next edge; no o_done; o_cmd_ready=1 the cycle after reset deasserts.
- Busy ignore: second valid held during fill -> not accepted until IDLE; its first write starts 2 cycles after accept.
